column_window_buffer: RTL and testbench

- Upstream stage of the 7-input column sorter in the median-filter pipeline.
- Accepts a raster-order 8-bit pixel stream and buffers six previous image lines.
- Each accepted pixel produces one vertically aligned 7-pixel column: rows y-6..y at column x.
- out0..out6 drive the sorter's in0..in6 directly; out_valid qualifies them.

---
 rtl/column_window_buffer.sv | 135 +++++++++++++
 tb/tb_column_window_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/column_window_buffer.sv
// -----------------------------------------------------------------------------
// column_window_buffer
//
// Upstream stage of the 7-input column sorter in the median-filter pipeline.
// Takes a raster-order pixel stream and keeps the six previous image lines in
// line buffers. Every accepted pixel produces a vertically aligned 7-pixel
// column (rows y-6..y at column x), registered one cycle after the pixel.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   sof        start of frame, qualified by pix_valid; marks pixel (0,0)
//   pix_valid  pix_in carries a valid pixel this cycle
//   pix_in     raster pixel
//   out0       pixel at row y-6 (oldest, top of column)
//   out1..out5 pixels at rows y-5..y-1
//   out6       pixel at row y (current pixel)
//   out_x      column index of the emitted column
//   out_valid  out0..out6 and out_x form a complete column
// -----------------------------------------------------------------------------
module column_window_buffer #(
    parameter int IMG_W = 640,
    parameter int PIX_W = 8,
    parameter int X_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] out0,
    output logic [PIX_W-1:0] out1,
    output logic [PIX_W-1:0] out2,
    output logic [PIX_W-1:0] out3,
    output logic [PIX_W-1:0] out4,
    output logic [PIX_W-1:0] out5,
    output logic [PIX_W-1:0] out6,
    output logic [X_W-1:0]   out_x,
    output logic             out_valid
);

    localparam int              NLB        = 6;
    localparam int              AW         = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [X_W-1:0]  X_LAST     = X_W'(IMG_W - 1);
    localparam logic [2:0]      LINES_FULL = 3'd6;

    logic [X_W-1:0]   x_q, x_d, x_cur;
    logic [2:0]       lines_filled_q, lines_filled_d, lines_cur;
    logic [PIX_W-1:0] col_q [7];
    logic [PIX_W-1:0] col_d [7];
    logic [X_W-1:0]   out_x_q, out_x_d;
    logic             out_valid_q, out_valid_d;

    // Line memories are deliberately not reset; stale lines are masked by
    // lines_filled instead.
    logic [PIX_W-1:0] lb_mem [NLB][IMG_W];
    logic [PIX_W-1:0] lb_rd  [NLB];
    logic [AW-1:0]    addr;

    // sof forces the current pixel to be (0,0) of a fresh frame.
    always_comb begin
        x_cur     = sof ? '0 : x_q;
        lines_cur = sof ? '0 : lines_filled_q;
        addr      = x_cur[AW-1:0];
        for (int k = 0; k < NLB; k++) begin
            lb_rd[k] = lb_mem[k][addr];
        end
    end

    always_comb begin
        x_d            = x_q;
        lines_filled_d = lines_filled_q;
        col_d          = col_q;
        out_x_d        = out_x_q;
        out_valid_d    = 1'b0;
        if (pix_valid) begin
            // Newest line buffer feeds out5, oldest (LB5) feeds out0.
            col_d[6] = pix_in;
            for (int k = 0; k < NLB; k++) begin
                col_d[5-k] = lb_rd[k];
            end
            out_x_d     = x_cur;
            out_valid_d = (lines_cur == LINES_FULL);
            if (x_cur == X_LAST) begin
                x_d = '0;
                if (lines_cur != LINES_FULL) begin
                    lines_filled_d = lines_cur + 3'd1;
                end else begin
                    lines_filled_d = lines_cur;
                end
            end else begin
                x_d            = x_cur + X_W'(1);
                lines_filled_d = lines_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q            <= '0;
            lines_filled_q <= '0;
            col_q          <= '{default: '0};
            out_x_q        <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            x_q            <= x_d;
            lines_filled_q <= lines_filled_d;
            col_q          <= col_d;
            out_x_q        <= out_x_d;
            out_valid_q    <= out_valid_d;
        end
    end

    // Read-before-write shift: each buffer takes what the newer one held at
    // this column before the update.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb_mem[0][addr] <= pix_in;
            for (int k = 1; k < NLB; k++) begin
                lb_mem[k][addr] <= lb_rd[k-1];
            end
        end
    end

    assign out0      = col_q[0];
    assign out1      = col_q[1];
    assign out2      = col_q[2];
    assign out3      = col_q[3];
    assign out4      = col_q[4];
    assign out5      = col_q[5];
    assign out6      = col_q[6];
    assign out_x     = out_x_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_column_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_column_window_buffer
//
// Directed bench for column_window_buffer with an 8-pixel line. Pixels carry
// value row*16 + x so every column has an easily predicted content.
// -----------------------------------------------------------------------------
module tb_column_window_buffer;

    localparam int IMG_W = 8;
    localparam int PIX_W = 8;
    localparam int X_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sof = 1'b0;
    logic             pix_valid = 1'b0;
    logic [PIX_W-1:0] pix_in = '0;
    logic [PIX_W-1:0] out0, out1, out2, out3, out4, out5, out6;
    logic [X_W-1:0]   out_x;
    logic             out_valid;

    int checks = 0;
    int errors = 0;

    column_window_buffer #(
        .IMG_W(IMG_W),
        .PIX_W(PIX_W),
        .X_W  (X_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sof      (sof),
        .pix_valid(pix_valid),
        .pix_in   (pix_in),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out4     (out4),
        .out5     (out5),
        .out6     (out6),
        .out_x    (out_x),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sof;
        bit          vld;
        logic [7:0]  pix;
        bit          exp_vld;
        logic [3:0]  exp_x;
        logic [55:0] exp_col;
        bit          chk_data;
    } vec_t;

    vec_t vecs[$];
    vec_t last;

    function automatic logic [55:0] col_now();
        return {out0, out1, out2, out3, out4, out5, out6};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel (r,x) of the current frame; column expected only from row 6 on.
    task automatic add_pix(input bit s, input int r, input int x);
        vec_t v;
        v.sof      = s;
        v.vld      = 1'b1;
        v.pix      = 8'(r * 16 + x);
        v.exp_vld  = (r >= 6);
        v.exp_x    = 4'(x);
        v.exp_col  = '0;
        v.chk_data = (r >= 6);
        if (r >= 6) begin
            for (int k = 0; k < 7; k++) begin
                v.exp_col[(6-k)*8 +: 8] = 8'((r - 6 + k) * 16 + x);
            end
        end
        vecs.push_back(v);
        last = v;
    endtask

    // Idle cycle: out_valid drops, everything else holds the last column.
    task automatic add_idle();
        vec_t v;
        v         = last;
        v.sof     = 1'b0;
        v.vld     = 1'b0;
        v.pix     = 8'hAA;
        v.exp_vld = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic send(input bit s, input int r, input int x);
        @(negedge clk);
        sof       = s;
        pix_valid = 1'b1;
        pix_in    = 8'(r * 16 + x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Gapless frame straight out of reset.
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < IMG_W; x++)
                add_pix(1'b0, r, x);
        // Same frame restarted with sof, pix_valid toggling every cycle.
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < IMG_W; x++) begin
                add_pix(r == 0 && x == 0, r, x);
                add_idle();
            end
        // Frame cut short by sof at (7,4), which becomes (0,0) of a new frame.
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < IMG_W; x++)
                if (!(r == 7 && x >= 4)) add_pix(r == 0 && x == 0, r, x);
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < IMG_W; x++)
                if (!(r == 7 && x >= 3)) add_pix(r == 0 && x == 0, r, x);

        #1 rst = 1'b0;
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_x", 64'(out_x), 64'd0);
        chk("reset_col", 64'(col_now()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            sof       = vecs[i].sof;
            pix_valid = vecs[i].vld;
            pix_in    = vecs[i].pix;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_x", i), 64'(out_x), 64'(vecs[i].exp_x));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_col", i), 64'(col_now()), 64'(vecs[i].exp_col));
        end

        // Asynchronous reset in the middle of row 7 of a valid stream.
        @(negedge clk);
        sof       = 1'b0;
        pix_valid = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("midreset_valid", 64'(out_valid), 64'd0);
        chk("midreset_x", 64'(out_x), 64'd0);
        chk("midreset_col", 64'(col_now()), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // After release: six lines of fill, then hand-computed columns.
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < IMG_W; x++) begin
                send(1'b0, r, x);
                chk($sformatf("post_rst_valid_r%0d_x%0d", r, x), 64'(out_valid), 64'(r >= 6));
                if (r == 6 && x == 0) begin
                    chk("first_col_x", 64'(out_x), 64'd0);
                    chk("first_col", 64'(col_now()), 64'h00_10_20_30_40_50_60);
                end
                if (r == 6 && x == 7) begin
                    chk("row_end_x", 64'(out_x), 64'd7);
                    chk("row_end_col", 64'(col_now()), 64'h07_17_27_37_47_57_67);
                end
                if (r == 7 && x == 0) begin
                    chk("wrap_x", 64'(out_x), 64'd0);
                    chk("wrap_col", 64'(col_now()), 64'h10_20_30_40_50_60_70);
                end
                if (r == 7 && x == 3) begin
                    chk("r7x3_x", 64'(out_x), 64'd3);
                    chk("r7x3_col", 64'(col_now()), 64'h13_23_33_43_53_63_73);
                end
            end
        @(negedge clk);
        pix_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
